fft_frame_feeder: RTL and testbench
===================================

FFT_FRAME_FEEDER -- requirements
Module: fft_frame_feeder

Interface
REQ-001 Parameter SAMPLE_W, default 8: signed input sample width.
REQ-002 Parameter COMP_W, default 8: width of each complex component of the output word; SHALL be >= SAMPLE_W.
REQ-003 Parameter FRAME_LEN, default 4096: samples per FFT frame; power of 2, >= 8.
REQ-004 Parameter HOP, default 4096: new samples between frame starts; 1 <= HOP <= FRAME_LEN (HOP < FRAME_LEN gives overlapped frames).
REQ-005 clk_in  input  1  single clock; all logic on rising edge.
REQ-006 rst_n_in  input  1  asynchronous active-low reset.
REQ-007 sample_in  input  SAMPLE_W  signed audio sample.
REQ-008 sample_valid_in  input  1  one-cycle strobe qualifying sample_in; no ready (source cannot stall).
REQ-009 m_tdata_out  output  2*COMP_W  {imag = 0, real = sign-extended sample}; real in low COMP_W bits.
REQ-010 m_tvalid_out  output  1  AXI-stream valid.
REQ-011 m_tlast_out  output  1  high on the last word of each frame.
REQ-012 m_tready_in  input  1  AXI-stream ready from the FFT core.
REQ-013 busy_out  output  1  high while a frame is being emitted or is pending.
REQ-014 overrun_out  output  1  sticky; set on any dropped sample or dropped frame.
REQ-015 drop_count_out  output  16  saturating count of dropped frames.

Function
REQ-016 Accepted samples SHALL be written to a circular buffer of depth 2*FRAME_LEN at wr_ptr, which increments modulo 2*FRAME_LEN.
REQ-017 A frame trigger SHALL occur on the cycle the FRAME_LEN-th accepted sample after reset is written, then on every HOP-th accepted sample thereafter.
REQ-018 A triggered frame SHALL consist of the last FRAME_LEN accepted samples, including the triggering sample, oldest first.
REQ-019 The FSM SHALL have the states IDLE and EMIT, plus a one-deep pending-frame register that holds a start address and a valid bit.
REQ-020 In IDLE, a trigger SHALL move the FSM to EMIT; the first m_tvalid_out SHALL be asserted 2 cycles after the trigger edge (1 cycle of RAM read plus 1 output register).
REQ-021 In EMIT, a trigger SHALL load the pending register; a trigger while pending is already valid SHALL drop that frame, set overrun_out, and increment drop_count_out (saturating at 16'hFFFF).
REQ-022 On the handshake of the word with m_tlast_out=1, the FSM SHALL go to EMIT from pending without an idle bubble if pending is valid; otherwise it SHALL go to IDLE.
REQ-023 AXI-stream rules: while m_tvalid_out=1 and m_tready_in=0, m_tdata_out and m_tlast_out SHALL be held stable; m_tvalid_out SHALL NOT deassert mid-frame.
REQ-024 With m_tready_in held high, the block SHALL sustain 1 word per cycle; m_tlast_out SHALL be high exactly once per FRAME_LEN words.
REQ-025 Fill is defined as (wr_ptr - oldest unhandshaken address of the in-flight frame) mod 2*FRAME_LEN, or the held sample count when IDLE. A sample arriving when fill == 2*FRAME_LEN SHALL be dropped: not written, not counted toward HOP, and overrun_out set.
REQ-026 A trigger and an output handshake of the last word on the same cycle SHALL be handled as a trigger in EMIT followed by the tlast handshake, so that the new frame starts next without loss.
REQ-027 A sample write and an output read on the same cycle SHALL both proceed; read data is never the word being written.
REQ-028 Real part = sample_in sign-extended to COMP_W bits; imaginary part = 0.

Reset
REQ-029 When rst_n_in is low, m_tvalid_out, m_tlast_out, busy_out, and overrun_out SHALL be 0 immediately (asynchronously) and drop_count_out SHALL be 0.
REQ-030 When rst_n_in is low, m_tdata_out SHALL be 0, the FSM SHALL go to IDLE, and pending, wr_ptr, and the hop/fill counters SHALL clear.
REQ-031 A reset mid-frame SHALL abandon that frame without asserting tlast; buffer contents are don't-care, and the first trigger after reset requires FRAME_LEN new samples.

Verification (FRAME_LEN=8, HOP=4, SAMPLE_W=8, COMP_W=12 unless stated)
REQ-032 Samples 1..8 with m_tready_in=1 -> one frame with real parts 1..8, imaginary 0, m_tlast_out on the 8th word, first valid 2 cycles after sample 8.
REQ-033 Continue with samples 9..12 -> second frame 5..12; sample -3 (8'hFD) appears as real 12'hFFD.
REQ-034 Random m_tready_in toggling during a frame -> data and tlast held stable under stall, order intact, exactly 8 words emitted.
REQ-035 m_tready_in=0 from the first frame's first word while samples 9..17 arrive -> trigger at 12 goes to pending, trigger at 16 is dropped (drop_count_out=1), sample 17 is dropped, overrun_out=1.
REQ-036 rst_n_in pulsed low mid-frame -> m_tvalid_out=0 asynchronously; the next frame emits only after 8 new samples.
REQ-037 HOP=8 with samples 1..16 -> frames 1..8 and 9..16 with no overlap; a back-to-back pending frame follows tlast with no bubble.

Source files
------------

// File: rtl/fft_frame_feeder.sv
// rtl/fft_frame_feeder.sv - buffers a real sample stream and replays overlapped frames as complex AXI-stream words
module fft_frame_feeder #(
  parameter int SAMPLE_W  = 8,
  parameter int COMP_W    = 8,
  parameter int FRAME_LEN = 4096,
  parameter int HOP       = 4096
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid_in,
  output logic [2*COMP_W-1:0] m_tdata_out,
  output logic                m_tvalid_out,
  output logic                m_tlast_out,
  input  logic                m_tready_in,
  output logic                busy_out,
  output logic                overrun_out,
  output logic [15:0]         drop_count_out
);

  localparam int AW = $clog2(2 * FRAME_LEN);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(FRAME_LEN) + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(2 * FRAME_LEN);
  localparam logic [PW-1:0] BACK_P  = PW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] FL_C    = CW'(FRAME_LEN);
  localparam logic [CW-1:0] FL_M1   = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] HOP_M1  = CW'(HOP - 1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  typedef enum logic {S_IDLE, S_EMIT} state_t;
  state_t r_state, w_state_nxt;

  logic [SAMPLE_W-1:0] r_mem [0:2*FRAME_LEN-1];

  // Pointers carry one extra wrap bit so a completely full buffer is distinguishable from empty.
  logic [PW-1:0]       r_wr_ext, r_hs_ext, r_pend_start;
  logic [AW-1:0]       r_rd_addr;
  logic [CW-1:0]       r_trig_cnt, r_rd_left;
  logic                r_primed, r_pend_valid, r_pend_rd;
  logic                r_s1_valid, r_s1_last;
  logic [SAMPLE_W-1:0] r_s1_data;
  logic                r_out_valid, r_out_last;
  logic [COMP_W-1:0]   r_out_real;
  logic                r_overrun;
  logic [15:0]         r_drop_cnt;

  logic [PW-1:0] w_fill, w_trig_start;
  logic [AW-1:0] w_rd_addr;
  logic w_full, w_accept, w_trig, w_out_hs, w_last_hs, w_out_load, w_s1_move;
  logic w_have_cur, w_have_pend, w_issue, w_pend_drop;

  assign w_fill       = r_wr_ext - r_hs_ext;
  assign w_full       = (r_state == S_EMIT) && (w_fill == DEPTH_P);
  assign w_accept     = sample_valid_in && !w_full;
  assign w_trig       = w_accept && (r_trig_cnt == (r_primed ? HOP_M1 : FL_M1));
  assign w_trig_start = r_wr_ext - BACK_P;
  assign w_out_hs     = r_out_valid && m_tready_in;
  assign w_last_hs    = w_out_hs && r_out_last;
  assign w_out_load   = !r_out_valid || m_tready_in;
  assign w_s1_move    = r_s1_valid && w_out_load;
  assign w_have_cur   = (r_rd_left != '0);
  // Once the current frame's reads are all issued, prefetch the pending frame so it follows tlast with no gap.
  assign w_have_pend  = r_pend_valid && !r_pend_rd;
  assign w_issue      = (r_state == S_EMIT) && (!r_s1_valid || w_out_load) && (w_have_cur || w_have_pend);
  assign w_rd_addr    = w_have_cur ? r_rd_addr : r_pend_start[AW-1:0];
  assign w_pend_drop  = w_trig && (r_state == S_EMIT) && r_pend_valid;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_trig) w_state_nxt = S_EMIT;
      S_EMIT: if (w_last_hs && !r_pend_valid && !w_trig) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (w_accept) r_mem[r_wr_ext[AW-1:0]] <= sample_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ext     <= '0;
      r_hs_ext     <= '0;
      r_pend_start <= '0;
      r_rd_addr    <= '0;
      r_trig_cnt   <= '0;
      r_rd_left    <= '0;
      r_primed     <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_rd    <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s1_data    <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_real   <= '0;
      r_overrun    <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ext <= r_wr_ext + PW'(1);
        if (w_trig) begin
          r_trig_cnt <= '0;
          r_primed   <= 1'b1;
        end else begin
          r_trig_cnt <= r_trig_cnt + CW'(1);
        end
      end
      if ((sample_valid_in && w_full) || w_pend_drop) r_overrun <= 1'b1;
      if (w_pend_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;

      if (w_issue) begin
        r_s1_valid <= 1'b1;
        r_s1_data  <= r_mem[w_rd_addr];
        r_s1_last  <= w_have_cur && (r_rd_left == CW'(1));
        if (w_have_cur) begin
          r_rd_addr <= r_rd_addr + ONE_A;
          r_rd_left <= r_rd_left - CW'(1);
        end else begin
          r_rd_addr <= r_pend_start[AW-1:0] + ONE_A;
          r_rd_left <= FL_M1;
          r_pend_rd <= 1'b1;
        end
      end else if (w_s1_move) begin
        r_s1_valid <= 1'b0;
      end

      if (w_out_load) begin
        r_out_valid <= r_s1_valid;
        r_out_last  <= r_s1_valid && r_s1_last;
        if (r_s1_valid) r_out_real <= COMP_W'($signed(r_s1_data));
      end
      if (w_out_hs) r_hs_ext <= r_hs_ext + PW'(1);

      if ((r_state == S_IDLE) && w_trig) begin
        r_rd_addr <= w_trig_start[AW-1:0];
        r_rd_left <= FL_C;
        r_hs_ext  <= w_trig_start;
      end
      if ((r_state == S_EMIT) && w_trig && !r_pend_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_start <= w_trig_start;
        r_pend_rd    <= 1'b0;
      end
      // A trigger landing with the tlast handshake has already been folded into pending above.
      if (w_last_hs) begin
        r_pend_valid <= 1'b0;
        r_pend_rd    <= 1'b0;
        if (r_pend_valid) begin
          r_hs_ext <= r_pend_start;
        end else if (w_trig) begin
          r_hs_ext  <= w_trig_start;
          r_rd_addr <= w_trig_start[AW-1:0];
          r_rd_left <= FL_C;
        end
      end
    end
  end

  assign m_tdata_out    = {{COMP_W{1'b0}}, r_out_real};
  assign m_tvalid_out   = r_out_valid;
  assign m_tlast_out    = r_out_last;
  assign busy_out       = (r_state == S_EMIT) || r_pend_valid;
  assign overrun_out    = r_overrun;
  assign drop_count_out = r_drop_cnt;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb/tb_fft_frame_feeder.sv - directed bench: frame contents, latency, stalls, overrun, reset, no-overlap hop
module tb_fft_frame_feeder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  s_a, s_b;
  logic        v_a, v_b, rdy_a, rdy_b;
  logic [23:0] d_a, d_b;
  logic        tv_a, tv_b, tl_a, tl_b, busy_a, busy_b, ovr_a, ovr_b;
  logic [15:0] dc_a, dc_b;

  int total = 0;
  int bad = 0;
  logic [23:0] got_d [0:15];
  logic        got_l [0:15];
  logic [7:0]  exp_v [0:15];
  int got_n, got_cyc, got_viol, early;

  fft_frame_feeder #(.SAMPLE_W(8), .COMP_W(12), .FRAME_LEN(8), .HOP(4)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .sample_in(s_a), .sample_valid_in(v_a),
    .m_tdata_out(d_a), .m_tvalid_out(tv_a), .m_tlast_out(tl_a), .m_tready_in(rdy_a),
    .busy_out(busy_a), .overrun_out(ovr_a), .drop_count_out(dc_a));

  fft_frame_feeder #(.SAMPLE_W(8), .COMP_W(12), .FRAME_LEN(8), .HOP(8)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .sample_in(s_b), .sample_valid_in(v_b),
    .m_tdata_out(d_b), .m_tvalid_out(tv_b), .m_tlast_out(tl_b), .m_tready_in(rdy_b),
    .busy_out(busy_b), .overrun_out(ovr_b), .drop_count_out(dc_b));

  function automatic logic [23:0] w(input logic [7:0] v);
    return {12'h000, {4{v[7]}}, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int which, input logic [7:0] v);
    if (which == 0) begin s_a = v; v_a = 1'b1; end
    else            begin s_b = v; v_b = 1'b1; end
    @(negedge clk);
    v_a = 1'b0;
    v_b = 1'b0;
  endtask

  // Records handshaken words; also counts stall-stability and mid-frame valid-drop violations.
  task automatic collect(input int which, input int n, input bit rnd);
    logic pv, pl, pr, cv, cl, r, started;
    logic [23:0] pd, cd;
    got_n = 0; got_cyc = 0; got_viol = 0;
    pv = 1'b0; pl = 1'b0; pr = 1'b1; pd = '0; started = 1'b0;
    for (int cyc = 0; cyc < 200 && got_n < n; cyc++) begin
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (which == 0) rdy_a = r; else rdy_b = r;
      cv = (which == 0) ? tv_a : tv_b;
      cd = (which == 0) ? d_a : d_b;
      cl = (which == 0) ? tl_a : tl_b;
      if (pv && !pr && (!cv || cd !== pd || cl !== pl)) got_viol++;
      if (started && !cv) got_viol++;
      if (cv && r) begin
        got_d[got_n] = cd;
        got_l[got_n] = cl;
        got_n++;
        started = !cl;
      end
      if (got_n > 0) got_cyc++;
      pv = cv; pd = cd; pl = cl; pr = r;
      @(negedge clk);
    end
  endtask

  task automatic chk_words(input string tag, input int n);
    logic [15:0] lm, em;
    lm = '0;
    em = '0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_w%0d", tag, i), got_d[i], w(exp_v[i]));
      lm[i] = got_l[i];
      if (i % 8 == 7) em[i] = 1'b1;
    end
    chk({tag, "_last"}, lm, em);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; v_a = 0; v_b = 0; s_a = 0; s_b = 0; rdy_a = 0; rdy_b = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tvalid", tv_a, 0);
    chk("rst_tlast", tl_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_overrun", ovr_a, 0);
    chk("rst_drop", dc_a, 0);
    chk("rst_tdata", d_a, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // first frame, latency of two cycles after the trigger edge
    rdy_a = 1'b1;
    for (int i = 1; i <= 8; i++) push(0, 8'(i));
    chk("lat0_valid", tv_a, 0);
    chk("trig_busy", busy_a, 1);
    @(negedge clk);
    chk("lat1_valid", tv_a, 0);
    @(negedge clk);
    chk("lat2_valid", tv_a, 1);
    collect(0, 8, 1'b0);
    chk("f1_count", got_n, 8);
    chk("f1_cycles", got_cyc, 8);
    for (int i = 0; i < 8; i++) exp_v[i] = 8'(i + 1);
    chk_words("f1", 8);
    chk("f1_idle_valid", tv_a, 0);
    chk("f1_idle_busy", busy_a, 0);

    // overlapped second frame with a negative sample, random backpressure
    push(0, 8'd9); push(0, 8'd10); push(0, 8'hFD); push(0, 8'd12);
    collect(0, 8, 1'b1);
    chk("f2_count", got_n, 8);
    chk("f2_stall_viol", got_viol, 0);
    exp_v[0] = 8'd5; exp_v[1] = 8'd6; exp_v[2] = 8'd7; exp_v[3] = 8'd8;
    exp_v[4] = 8'd9; exp_v[5] = 8'd10; exp_v[6] = 8'hFD; exp_v[7] = 8'd12;
    chk_words("f2", 8);

    // stalled sink: pending frame, dropped frame, dropped sample
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rdy_a = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 12; i++) push(0, 8'(i));
    chk("ov12_drop", dc_a, 0);
    chk("ov12_overrun", ovr_a, 0);
    chk("ov12_busy", busy_a, 1);
    for (int i = 13; i <= 16; i++) push(0, 8'(i));
    chk("ov16_drop", dc_a, 1);
    chk("ov16_overrun", ovr_a, 1);
    push(0, 8'd17);
    chk("ov17_drop", dc_a, 1);
    chk("ov_hold_valid", tv_a, 1);
    chk("ov_hold_data", d_a, w(8'd1));
    collect(0, 16, 1'b0);
    chk("ov_count", got_n, 16);
    chk("ov_b2b_cycles", got_cyc, 16);
    chk("ov_viol", got_viol, 0);
    for (int i = 0; i < 8; i++) begin
      exp_v[i] = 8'(i + 1);
      exp_v[i + 8] = 8'(i + 5);
    end
    chk_words("ov", 16);

    // dropped sample 17 was neither stored nor counted toward the hop
    push(0, 8'h41); push(0, 8'h42); push(0, 8'h43);
    early = 0;
    repeat (3) begin
      if (tv_a) early++;
      @(negedge clk);
    end
    chk("hop_no_early", early, 0);
    push(0, 8'h44);
    collect(0, 3, 1'b0);
    rdy_a = 1'b0;
    chk("f4_count", got_n, 3);
    exp_v[0] = 8'd13; exp_v[1] = 8'd14; exp_v[2] = 8'd15;
    for (int i = 0; i < 3; i++) chk($sformatf("f4_w%0d", i), got_d[i], w(exp_v[i]));
    chk("pre_rst_valid", tv_a, 1);
    chk("pre_rst_data", d_a, w(8'd16));

    // asynchronous reset mid-frame
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", tv_a, 0);
    chk("mid_rst_last", tl_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_overrun", ovr_a, 0);
    chk("mid_rst_drop", dc_a, 0);
    chk("mid_rst_data", d_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_a = 1'b1;
    @(negedge clk);
    early = 0;
    for (int i = 0; i < 4; i++) push(0, 8'(8'h31 + i));
    repeat (4) begin
      if (tv_a) early++;
      @(negedge clk);
    end
    chk("post_rst_no_early", early, 0);
    for (int i = 4; i < 8; i++) push(0, 8'(8'h31 + i));
    collect(0, 8, 1'b0);
    chk("f5_count", got_n, 8);
    for (int i = 0; i < 8; i++) exp_v[i] = 8'(8'h31 + i);
    chk_words("f5", 8);

    // HOP = FRAME_LEN: disjoint frames, pending frame follows tlast with no bubble
    rdy_b = 1'b0;
    for (int i = 1; i <= 16; i++) push(1, 8'(i));
    chk("h8_busy", busy_b, 1);
    chk("h8_hold_data", d_b, w(8'd1));
    chk("h8_drop", dc_b, 0);
    chk("h8_overrun", ovr_b, 0);
    collect(1, 16, 1'b0);
    chk("h8_count", got_n, 16);
    chk("h8_b2b_cycles", got_cyc, 16);
    for (int i = 0; i < 16; i++) exp_v[i] = 8'(i + 1);
    chk_words("h8", 16);
    chk("h8_idle_busy", busy_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
